// File: rtl/jtcontra_gfx_tilemap_n.sv
// Multi-layer tilemap scanline renderer.
// Per line, walks each layer in 4-pixel chunks: scans the tile VRAM,
// fetches a 16-bit ROM half-row, and dumps four pixels into the line buffer.
// Supports per-tile hflip, fine scroll with left/right clipping and a
// configurable visible width.
module jtcontra_gfx_tilemap_n #(
   parameter int LAYERS = 2,
   parameter int LINE_W = 320
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  LHBL,
   input  logic                  LVBL,
   input  logic [8:0]            vrender,
   input  logic [LAYERS*9-1:0]   hscr,
   input  logic [LAYERS*8-1:0]   vscr,
   input  logic [LAYERS*9-1:0]   dump_start,
   output logic [11:0]           scan_addr,
   input  logic [7:0]            attr_scan,
   input  logic [7:0]            code_scan,
   output logic                  rom_cs,
   output logic [16:0]           rom_addr,
   input  logic                  rom_ok,
   input  logic [15:0]           rom_data,
   output logic                  line,
   output logic [9:0]            line_addr,
   output logic [7:0]            line_din,
   output logic                  line_we,
   output logic [1:0]            line_lyr,
   output logic                  done
);

   localparam logic [8:0] LW = 9'(LINE_W);

   typedef enum logic [2:0] {IDLE, SETUP, SCAN, FETCH, DUMP, NEXT} t_state;

   t_state      r_state, w_next;
   logic        r_lhbl;
   logic [1:0]  r_lyr;
   logic [7:0]  r_vn;
   logic [8:0]  r_hn;
   logic [9:0]  r_px;        // signed: starts at -hscr[1:0]
   logic [10:0] r_code;
   logic [3:0]  r_pal;
   logic        r_flip;
   logic [15:0] r_data;
   logic [1:0]  r_cnt;       // SCAN wait / DUMP pixel counter
   logic        r_done;
   logic        r_line;

   logic [8:0]  w_hscr, w_dstart;
   logic [7:0]  w_vscr;
   logic        w_start, w_px_vis, w_px_end, w_last;
   logic [8:0]  w_hn_nx;
   logic [1:0]  w_idx;
   logic [3:0]  w_nib;
   logic        w_unused_ok;

   assign w_unused_ok = vrender[8];

   // Select the scroll/placement settings of the layer being rendered
   always_comb begin
      w_hscr   = '0;
      w_vscr   = '0;
      w_dstart = '0;
      for (int k = 0; k < LAYERS; k++) begin
         if (r_lyr == 2'(k)) begin
            w_hscr   = hscr[9*k +: 9];
            w_vscr   = vscr[8*k +: 8];
            w_dstart = dump_start[9*k +: 9];
         end
      end
   end

   assign w_start  = LHBL & ~r_lhbl & LVBL;
   assign w_px_vis = ~r_px[9] && (r_px[8:0] <  LW);
   assign w_px_end = ~r_px[9] && (r_px[8:0] >= LW);
   assign w_last   = (r_lyr == 2'(LAYERS-1));
   assign w_hn_nx  = r_hn + 9'd4;
   // Flip reverses nibble order: index 3-cnt == cnt ^ 3
   assign w_idx    = r_cnt ^ {2{r_flip}};

   // Pick the current pixel nibble, leftmost first
   always_comb begin
      case (w_idx)
         2'd0:    w_nib = r_data[15:12];
         2'd1:    w_nib = r_data[11:8];
         2'd2:    w_nib = r_data[7:4];
         default: w_nib = r_data[3:0];
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic; a line start overrides whatever is in progress
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = IDLE;
         SETUP:   w_next = SCAN;
         SCAN:    if (r_cnt == 2'd1) w_next = FETCH;
         FETCH:   if (rom_ok) w_next = DUMP;
         DUMP:    if (r_cnt == 2'd3) w_next = NEXT;
         NEXT: begin
            if (w_px_end)        w_next = w_last ? IDLE : SETUP;
            else if (w_hn_nx[2]) w_next = FETCH;   // other half of same tile
            else                 w_next = SCAN;
         end
         default: w_next = IDLE;
      endcase
      if (w_start) w_next = SETUP;
   end

   // Datapath: scroll setup, tile latch, ROM latch, pixel/column stepping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lhbl <= 1'b0;
         r_lyr  <= '0;
         r_vn   <= '0;
         r_hn   <= '0;
         r_px   <= '0;
         r_code <= '0;
         r_pal  <= '0;
         r_flip <= 1'b0;
         r_data <= '0;
         r_cnt  <= '0;
         r_done <= 1'b1;
         r_line <= 1'b0;
      end else begin
         r_lhbl <= LHBL;
         r_cnt  <= (w_next != r_state) ? 2'd0 : r_cnt + 2'd1;
         if (w_start) begin
            r_line <= ~r_line;
            r_lyr  <= '0;
            r_done <= 1'b0;
         end else begin
            case (r_state)
               SETUP: begin
                  r_vn <= vrender[7:0] + w_vscr;
                  r_hn <= {w_hscr[8:2], 2'b00};
                  r_px <= 10'd0 - {8'd0, w_hscr[1:0]};
               end
               SCAN: if (r_cnt == 2'd1) begin
                  r_code <= {attr_scan[7:5], code_scan};
                  r_pal  <= attr_scan[3:0];
                  r_flip <= attr_scan[4];
               end
               FETCH: if (rom_ok) r_data <= rom_data;
               DUMP:  r_px <= r_px + 10'd1;
               NEXT: begin
                  if (w_px_end) begin
                     if (w_last) r_done <= 1'b1;
                     else        r_lyr  <= r_lyr + 2'd1;
                  end else begin
                     r_hn <= w_hn_nx;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Outputs decoded from state and datapath registers
   always_comb begin
      rom_cs    = (r_state == FETCH);
      line_we   = (r_state == DUMP) && w_px_vis;
      line_din  = (r_state == DUMP) ? {r_pal, w_nib} : 8'd0;
      line_addr = {r_line, w_dstart + r_px[8:0]};
      scan_addr = {r_lyr, r_vn[7:3], r_hn[7:3]};
      rom_addr  = {r_lyr, r_code, r_vn[2:0], r_hn[2] ^ r_flip};
      line      = r_line;
      line_lyr  = r_lyr;
      done      = r_done;
   end

endmodule

// File: tb/tb_jtcontra_gfx_tilemap_n.sv
// Directed bench for the tilemap line renderer (LAYERS=2, LINE_W=320).
module tb_jtcontra_gfx_tilemap_n;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        LHBL, LVBL;
   logic [8:0]  vrender;
   logic [17:0] hscr, dump_start;
   logic [15:0] vscr;
   logic [11:0] scan_addr;
   logic [7:0]  attr_scan, code_scan;
   logic        rom_cs, rom_ok;
   logic [16:0] rom_addr;
   logic [15:0] rom_data;
   logic        line, line_we, done;
   logic [9:0]  line_addr;
   logic [7:0]  line_din;
   logic [1:0]  line_lyr;

   // stimulus model knobs
   logic [7:0]  vr_code, vr_attr, vr_attr_alt;
   logic [4:0]  vr_row;
   logic [15:0] d0, d1;
   logic        rom_en;
   logic        exp_line;

   int n_vec = 0, n_bad = 0;

   logic [9:0] q_addr[$];
   logic [7:0] q_din[$];
   logic [1:0] q_lyr[$];
   logic [16:0] q_rom[$];

   jtcontra_gfx_tilemap_n #(.LAYERS(2), .LINE_W(320)) dut (
      .clk(clk), .rst_n(rst_n), .LHBL(LHBL), .LVBL(LVBL), .vrender(vrender),
      .hscr(hscr), .vscr(vscr), .dump_start(dump_start), .scan_addr(scan_addr),
      .attr_scan(attr_scan), .code_scan(code_scan), .rom_cs(rom_cs),
      .rom_addr(rom_addr), .rom_ok(rom_ok), .rom_data(rom_data), .line(line),
      .line_addr(line_addr), .line_din(line_din), .line_we(line_we),
      .line_lyr(line_lyr), .done(done)
   );

   always #5 clk = ~clk;

   // synchronous VRAM: row vr_row gets vr_attr, any other row vr_attr_alt
   always @(posedge clk) begin
      code_scan <= vr_code;
      attr_scan <= (scan_addr[9:5] == vr_row) ? vr_attr : vr_attr_alt;
   end

   // zero-latency ROM selected by hsel
   assign rom_ok   = rom_cs & rom_en;
   assign rom_data = rom_addr[0] ? d1 : d0;

   // record writes and ROM accepts away from the active edge
   always @(negedge clk) begin
      if (rst_n) begin
         if (line_we) begin
            q_addr.push_back(line_addr);
            q_din.push_back(line_din);
            q_lyr.push_back(line_lyr);
         end
         if (rom_cs && rom_ok) q_rom.push_back(rom_addr);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic start_line();
      @(posedge clk); #1 LHBL = 1'b0;
      repeat (2) @(posedge clk);
      #1 LHBL = 1'b1;
      if (LVBL) exp_line = ~exp_line;
      @(posedge clk); #1;
      q_addr.delete(); q_din.delete(); q_lyr.delete(); q_rom.delete();
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done && n < budget) begin
         @(negedge clk); n++;
      end
      chk("done_rise", done, 1'b1);
   endtask

   // per-layer summary: count, first/last x, first/last din, x-step or line-bit errors
   task automatic layer_info(input logic [1:0] l, output int cnt, output int fx,
                             output int lx, output int fd, output int ld, output int gaps);
      int px = -1;
      cnt = 0; fx = -1; lx = -1; fd = -1; ld = -1; gaps = 0;
      for (int i = 0; i < q_addr.size(); i++) begin
         if (q_lyr[i] == l) begin
            if (cnt == 0) begin fx = q_addr[i][8:0]; fd = q_din[i]; end
            else if (q_addr[i][8:0] != 9'(px + 1)) gaps++;
            if (q_addr[i][9] != exp_line) gaps++;
            px = q_addr[i][8:0]; lx = px; ld = q_din[i];
            cnt++;
         end
      end
   endtask

   initial begin
      int c, fx, lx, fd, ld, g, bad;
      int idx[2];
      rst_n = 1'b0; LHBL = 1'b0; LVBL = 1'b1; vrender = '0;
      hscr = '0; vscr = '0; dump_start = '0;
      vr_code = 8'h12; vr_attr = 8'h05; vr_attr_alt = 8'h05; vr_row = '0;
      d0 = 16'h1234; d1 = 16'h1234; rom_en = 1'b1; exp_line = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_done", done, 1'b1);
      chk("rst_line", line, 1'b0);
      chk("rst_romcs", rom_cs, 1'b0);
      chk("rst_we", line_we, 1'b0);
      chk("rst_din", line_din, 8'h00);
      chk("rst_lyr", line_lyr, 2'd0);
      rst_n = 1'b1;

      // LVBL low: no line start
      LVBL = 1'b0;
      start_line();
      @(negedge clk);
      chk("vbl_line", line, 1'b0);
      chk("vbl_done", done, 1'b1);
      LVBL = 1'b1;

      // basic two-layer line, no scroll
      start_line();
      @(negedge clk);
      chk("start_line_bit", line, exp_line);
      chk("start_done_low", done, 1'b0);
      wait_done(4000);
      layer_info(2'd0, c, fx, lx, fd, ld, g);
      chk("b_l0_cnt", c, 320); chk("b_l0_fx", fx, 0); chk("b_l0_lx", lx, 319);
      chk("b_l0_gaps", g, 0);
      layer_info(2'd1, c, fx, lx, fd, ld, g);
      chk("b_l1_cnt", c, 320); chk("b_l1_lx", lx, 319); chk("b_l1_gaps", g, 0);
      bad = 0; idx[0] = 0; idx[1] = 0;
      for (int i = 0; i < q_din.size(); i++) begin
         if (q_din[i] != 8'h51 + 8'(idx[q_lyr[i][0]] % 4)) bad++;
         idx[q_lyr[i][0]]++;
      end
      chk("b_pattern", bad, 0);
      chk("b_rom_code", q_rom[0][14:4], 11'h012);
      chk("b_rom_lyr_last", q_rom[q_rom.size()-1][16:15], 2'd1);

      // fine scroll 3 and 9-bit wrap of line x on layer 1
      hscr = {9'h003, 9'h003}; dump_start = {9'h1F0, 9'h000};
      start_line();
      wait_done(4000);
      layer_info(2'd0, c, fx, lx, fd, ld, g);
      chk("s_l0_cnt", c, 320); chk("s_l0_fx", fx, 0); chk("s_l0_fd", fd, 8'h54);
      chk("s_l0_lx", lx, 319); chk("s_l0_ld", ld, 8'h53);
      layer_info(2'd1, c, fx, lx, fd, ld, g);
      chk("s_l1_cnt", c, 320); chk("s_l1_fx", fx, 9'h1F0); chk("s_l1_lx", lx, 303);
      chk("s_l1_gaps", g, 0);
      hscr = '0; dump_start = '0;

      // hflip: half select and nibble order
      vr_attr = 8'h15; vr_attr_alt = 8'h15; d0 = 16'h1111; d1 = 16'h2222;
      start_line();
      wait_done(4000);
      chk("f_hsel_first", q_rom[0][0], 1'b1);
      chk("f_half_a", {q_din[0], q_din[1], q_din[2], q_din[3]}, 32'h52525252);
      chk("f_half_b", {q_din[4], q_din[5], q_din[6], q_din[7]}, 32'h51515151);
      d0 = 16'hABCD; d1 = 16'hABCD;
      start_line();
      wait_done(4000);
      chk("f_reverse", {q_din[0], q_din[1], q_din[2], q_din[3]}, 32'h5D5C5B5A);

      // vertical scroll wrap: 0x10 + 0xF8 -> row 1, fine row 0
      vr_attr = 8'h05; vr_attr_alt = 8'h0F; vr_row = 5'd1;
      d0 = 16'h1234; d1 = 16'h1234; vscr = {8'hF8, 8'hF8}; vrender = 9'h010;
      start_line();
      wait_done(4000);
      chk("v_fine_row", q_rom[0][3:1], 3'd0);
      chk("v_first_din", q_din[0], 8'h51);
      bad = 0;
      foreach (q_din[i]) if (q_din[i][7:4] != 4'h5) bad++;
      chk("v_row_pal", bad, 0);
      vscr = '0; vrender = '0; vr_attr_alt = 8'h05; vr_row = '0;

      // ROM stall, then a new line start aborts and restarts
      rom_en = 1'b0;
      start_line();
      repeat (50) @(negedge clk);
      chk("st_cs_held", rom_cs, 1'b1);
      chk("st_no_we", q_addr.size(), 0);
      start_line();
      @(negedge clk);
      chk("st_cs_drop", rom_cs, 1'b0);
      chk("st_line", line, exp_line);
      chk("st_lyr", line_lyr, 2'd0);
      rom_en = 1'b1;
      wait_done(4000);
      layer_info(2'd0, c, fx, lx, fd, ld, g);
      chk("st_l0_cnt", c, 320); chk("st_l0_fx", fx, 0);

      // async reset in the middle of a fetch
      rom_en = 1'b0;
      start_line();
      repeat (10) @(negedge clk);
      chk("ar_cs_before", rom_cs, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_cs", rom_cs, 1'b0);
      chk("ar_done", done, 1'b1);
      chk("ar_line", line, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
